idct_8x8_serial: RTL and testbench

- Inverse 2-D 8x8 DCT engine; the decode-side counterpart of the forward DCT cosine-LUT datapath.
- Accepts one block of 64 signed coefficients in raster order over a valid/ready stream and buffers it.
- Computes each pixel with a serial multiply-accumulate over all 64 basis terms, then emits 64 level-shifted, clamped 8-bit pixels in raster order over a second valid/ready stream.

---
 rtl/dct_pkg.sv | 29 ++
 rtl/idct_basis_rom.sv | 19 +
 rtl/idct_8x8_serial.sv | 151 +++++++++++++++
 tb/tb_idct_8x8_serial.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants for the 8x8 DCT engines: default widths, FSM states and
// the signed Q8 cosine basis table W[k][n] = round(128 * C(k) * cos((2n+1)k*pi/16)).
package dct_pkg;

    localparam int COEF_W_DEF      = 12;
    localparam int PIX_W_DEF       = 8;
    localparam int ACC_W_DEF       = 34;
    localparam int LEVEL_SHIFT_DEF = 128;
    localparam int WPROD_W         = 18;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        EMIT  = 2'd3
    } state_t;

    localparam logic signed [8:0] BASIS [8][8] = '{
        '{ 9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91  },
        '{ 9'sd126,  9'sd106,  9'sd71,   9'sd25,  -9'sd25,  -9'sd71,  -9'sd106, -9'sd126 },
        '{ 9'sd118,  9'sd49,  -9'sd49,  -9'sd118, -9'sd118, -9'sd49,   9'sd49,   9'sd118 },
        '{ 9'sd106, -9'sd25,  -9'sd126, -9'sd71,   9'sd71,   9'sd126,  9'sd25,  -9'sd106 },
        '{ 9'sd91,  -9'sd91,  -9'sd91,   9'sd91,   9'sd91,  -9'sd91,  -9'sd91,   9'sd91  },
        '{ 9'sd71,  -9'sd126,  9'sd25,   9'sd106, -9'sd106, -9'sd25,   9'sd126, -9'sd71  },
        '{ 9'sd49,  -9'sd118,  9'sd118, -9'sd49,  -9'sd49,   9'sd118, -9'sd118,  9'sd49  },
        '{ 9'sd25,  -9'sd71,   9'sd106, -9'sd126,  9'sd126, -9'sd106,  9'sd71,  -9'sd25  }
    };

endpackage

// File: rtl/idct_basis_rom.sv
// Combinational 2-D basis lookup: W(k1,n1) * W(k2,n2) as an 18-bit signed product.
module idct_basis_rom
    import dct_pkg::*;
(
    input  logic [2:0]                k1,
    input  logic [2:0]                n1,
    input  logic [2:0]                k2,
    input  logic [2:0]                n2,
    output logic signed [WPROD_W-1:0] wprod
);

    logic signed [WPROD_W-1:0] wa;
    logic signed [WPROD_W-1:0] wb;

    assign wa    = WPROD_W'(BASIS[k1][n1]);
    assign wb    = WPROD_W'(BASIS[k2][n2]);
    assign wprod = wa * wb;

endmodule

// File: rtl/idct_8x8_serial.sv
// Serial 8x8 inverse DCT: buffers 64 coefficients, then one 64-term MAC pass per
// output pixel, descaled, level-shifted and clamped.
//   state | meaning
//   LOAD  | accepting coefficients into the block buffer
//   MAC   | issuing the 64 basis terms of the current pixel
//   DRAIN | two cycles letting the product/accumulate pipeline empty
//   EMIT  | pixel presented, waiting for pix_ready
module idct_8x8_serial
    import dct_pkg::*;
#(
    parameter int COEF_W      = COEF_W_DEF,
    parameter int PIX_W       = PIX_W_DEF,
    parameter int ACC_W       = ACC_W_DEF,
    parameter int LEVEL_SHIFT = LEVEL_SHIFT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              coef_valid,
    output logic              coef_ready,
    input  logic [COEF_W-1:0] coef_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_last
);

    localparam int P_W = COEF_W + WPROD_W;
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(32768);
    localparam logic signed [ACC_W-1:0] SHIFT   = ACC_W'(LEVEL_SHIFT);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

    state_t                    state;
    state_t                    next_state;
    logic [5:0]                cnt;
    logic [5:0]                pix_idx;
    logic                      drain_tmr;
    logic signed [COEF_W-1:0]  coef_buf [64];
    logic signed [WPROD_W-1:0] wprod;
    logic signed [P_W-1:0]     coef_x;
    logic signed [P_W-1:0]     wprod_x;
    logic signed [P_W-1:0]     prod;
    logic                      prod_vld;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_rnd;
    logic signed [ACC_W-1:0]   s;
    logic signed [ACC_W-1:0]   v;
    logic [PIX_W-1:0]          pix_next;
    logic                      coef_fire;
    logic                      pix_fire;

    assign coef_fire = coef_valid & coef_ready & (state == LOAD);
    assign pix_fire  = pix_valid & pix_ready;

    idct_basis_rom u_rom (
        .k1    (cnt[5:3]),
        .n1    (pix_idx[5:3]),
        .k2    (cnt[2:0]),
        .n2    (pix_idx[2:0]),
        .wprod (wprod)
    );

    assign coef_x  = P_W'(coef_buf[cnt]);
    assign wprod_x = P_W'(wprod);

    always_comb begin
        next_state = state;
        case (state)
            LOAD:  if (coef_fire && cnt == 6'd63) next_state = MAC;
            MAC:   if (cnt == 6'd63) next_state = DRAIN;
            DRAIN: if (drain_tmr == 1'b0) next_state = EMIT;
            EMIT:  if (pix_fire) next_state = (pix_idx == 6'd63) ? LOAD : MAC;
            default: next_state = LOAD;
        endcase
    end

    // Round-half-up descale (arithmetic shift floors), then level shift and clamp.
    always_comb begin
        acc_rnd  = acc + RND;
        s        = acc_rnd >>> 16;
        v        = s + SHIFT;
        pix_next = v[PIX_W-1:0];
        if (v < 0)
            pix_next = '0;
        else if (v > PIX_MAX)
            pix_next = '1;
    end

    always_ff @(posedge clk) begin
        if (coef_fire)
            coef_buf[cnt] <= $signed(coef_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            cnt        <= '0;
            pix_idx    <= '0;
            drain_tmr  <= 1'b0;
            prod       <= '0;
            prod_vld   <= 1'b0;
            acc        <= '0;
            coef_ready <= 1'b0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            pix_last   <= 1'b0;
        end else begin
            state      <= next_state;
            coef_ready <= (next_state == LOAD);
            pix_valid  <= (next_state == EMIT);
            prod_vld   <= (state == MAC);

            if (state == MAC)
                prod <= coef_x * wprod_x;

            // Stage 2 lags stage 1 by a cycle, so the first MAC cycle adds nothing.
            if (next_state == MAC && state != MAC)
                acc <= '0;
            else if (prod_vld)
                acc <= acc + ACC_W'(prod);

            case (state)
                LOAD: begin
                    pix_idx <= '0;
                    if (coef_fire)
                        cnt <= cnt + 6'd1;
                end
                MAC: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd63)
                        drain_tmr <= 1'b1;
                end
                DRAIN: begin
                    drain_tmr <= drain_tmr - 1'b1;
                    if (drain_tmr == 1'b0) begin
                        pix_data <= pix_next;
                        pix_last <= (pix_idx == 6'd63);
                    end
                end
                EMIT: begin
                    if (pix_fire) begin
                        pix_idx  <= pix_idx + 6'd1;
                        pix_last <= 1'b0;
                        cnt      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_idct_8x8_serial.sv
// Directed bench for idct_8x8_serial: hand-computed pixel values, a bit-exact
// reference built from real-valued cosines, latency, backpressure and reset checks.
module tb_idct_8x8_serial;

    typedef logic signed [11:0] blk_t [64];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        coef_valid;
    logic        coef_ready;
    logic [11:0] coef_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic        pix_last;

    idct_8x8_serial dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_data  (coef_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_last   (pix_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_chk = 0;
    int         n_pass = 0;
    int         wt [8][8];
    logic [7:0] got [64];
    int         rx_n;
    int         mac_cyc;
    int         first_valid_cyc;
    int         last_hs_cyc;
    int         first_acc_cyc;
    int         stable_err;
    int         cr_err;
    blk_t       blk_a;
    blk_t       blk_b;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int model(input blk_t b, input int idx);
        longint acc;
        longint s;
        int n1;
        int n2;
        acc = 0;
        n1  = idx / 8;
        n2  = idx % 8;
        for (int j = 0; j < 64; j++)
            acc += longint'(b[j]) * longint'(wt[j / 8][n1]) * longint'(wt[j % 8][n2]);
        s = ((acc + 64'sd32768) >>> 16) + 128;
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        return int'(s);
    endfunction

    task automatic send_block(input blk_t b, input bit gapped);
        int budget;
        for (int i = 0; i < 64; i++) begin
            if (gapped) begin
                coef_valid = 1'b0;
                repeat ($urandom_range(0, 2)) step;
            end
            coef_valid = 1'b1;
            coef_data  = b[i];
            budget     = 0;
            while (!coef_ready) begin
                step;
                budget++;
                if (budget > 20000) begin
                    chk("coef_timeout", 0, 1);
                    coef_valid = 1'b0;
                    return;
                end
            end
            step;
            if (i == 0)  first_acc_cyc = cyc;
            if (i == 63) mac_cyc = cyc;
        end
        coef_valid = 1'b0;
    endtask

    task automatic recv(input int n, input bit rnd);
        int         budget;
        bit         stalled;
        logic [7:0] held;
        stalled = 1'b0;
        held    = '0;
        for (int k = 0; k < n; k++) begin
            budget = 0;
            forever begin
                if (stalled && (!pix_valid || pix_data !== held)) stable_err++;
                if (pix_valid && rx_n == 0 && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (coef_ready) cr_err++;
                pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (pix_valid && pix_ready) break;
                stalled = pix_valid;
                held    = pix_data;
                step;
                budget++;
                if (budget > 5000) begin
                    chk("pix_timeout", 0, 1);
                    pix_ready = 1'b0;
                    return;
                end
            end
            chk($sformatf("pix_last[%0d]", rx_n), longint'(pix_last), longint'(rx_n == 63));
            got[rx_n] = pix_data;
            step;
            if (rx_n == 63) last_hs_cyc = cyc;
            rx_n++;
            stalled = 1'b0;
        end
        pix_ready = 1'b0;
    endtask

    task automatic check_model(input string tag, input blk_t b);
        for (int i = 0; i < 64; i++)
            chk($sformatf("%s[%0d]", tag, i), longint'(got[i]), longint'(model(b, i)));
    endtask

    task automatic check_const(input string tag, input int val);
        for (int i = 0; i < 64; i++)
            chk($sformatf("%s[%0d]", tag, i), longint'(got[i]), longint'(val));
    endtask

    task automatic fill_dc(output blk_t b, input int dc);
        for (int i = 0; i < 64; i++) b[i] = '0;
        b[0] = 12'(dc);
    endtask

    task automatic fill_rand(output blk_t b);
        for (int i = 0; i < 64; i++) b[i] = 12'($urandom_range(0, 400)) - 12'd200;
        b[0] = 12'($urandom_range(0, 1200)) - 12'd600;
    endtask

    task automatic run_block(input blk_t b, input bit gapped, input bit rnd);
        send_block(b, gapped);
        rx_n            = 0;
        first_valid_cyc = -1;
        recv(64, rnd);
    endtask

    initial begin
        real pi;
        real c;
        int  budget;
        pi = 3.14159265358979323846;
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++) begin
                c = (k == 0) ? 128.0 / $sqrt(2.0) : 128.0;
                wt[k][n] = int'(c * $cos(real'((2 * n + 1) * k) * pi / 16.0));
            end

        rst_n      = 1'b0;
        coef_valid = 1'b0;
        coef_data  = '0;
        pix_ready  = 1'b0;
        repeat (3) step;
        chk("rst_coef_ready", longint'(coef_ready), 0);
        chk("rst_pix_valid",  longint'(pix_valid), 0);
        chk("rst_pix_data",   longint'(pix_data), 0);
        chk("rst_pix_last",   longint'(pix_last), 0);
        rst_n = 1'b1;
        step;
        chk("post_rst_coef_ready", longint'(coef_ready), 1);
        chk("post_rst_pix_valid",  longint'(pix_valid), 0);

        fill_dc(blk_a, 0);
        run_block(blk_a, 1'b0, 1'b0);
        chk("latency", longint'(first_valid_cyc - mac_cyc), 66);
        check_const("zero", 128);

        fill_dc(blk_a, 512);
        run_block(blk_a, 1'b0, 1'b0);
        check_const("dc512", 193);

        fill_dc(blk_a, 1024);
        run_block(blk_a, 1'b0, 1'b0);
        check_const("dc1024", 255);

        fill_dc(blk_a, -1024);
        run_block(blk_a, 1'b0, 1'b0);
        check_const("dcm1024", 0);

        fill_dc(blk_a, 0);
        blk_a[1] = 12'sd256;
        run_block(blk_a, 1'b0, 1'b0);
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("x01_n2_0_row%0d", r), longint'(got[r * 8]), 173);
            chk($sformatf("x01_n2_7_row%0d", r), longint'(got[r * 8 + 7]), 83);
        end
        check_model("x01", blk_a);

        fill_rand(blk_a);
        stable_err = 0;
        cr_err     = 0;
        run_block(blk_a, 1'b0, 1'b1);
        chk("bp_stable_errs", longint'(stable_err), 0);
        chk("bp_coef_ready_errs", longint'(cr_err), 0);
        check_model("rand_bp", blk_a);

        fill_rand(blk_a);
        fill_rand(blk_b);
        send_block(blk_a, 1'b1);
        rx_n            = 0;
        first_valid_cyc = -1;
        fork
            send_block(blk_b, 1'b1);
            recv(64, 1'b1);
        join
        check_model("b2b_a", blk_a);
        chk("b2b_accept_after_last", longint'(first_acc_cyc > last_hs_cyc), 1);
        rx_n            = 0;
        first_valid_cyc = -1;
        recv(64, 1'b1);
        check_model("b2b_b", blk_b);

        fill_rand(blk_a);
        send_block(blk_a, 1'b0);
        rx_n            = 0;
        first_valid_cyc = -1;
        recv(10, 1'b0);
        repeat (5) step;
        rst_n = 1'b0;
        #1;
        chk("midrst_pix_valid",  longint'(pix_valid), 0);
        chk("midrst_coef_ready", longint'(coef_ready), 0);
        chk("midrst_pix_data",   longint'(pix_data), 0);
        step;
        rst_n = 1'b1;
        step;
        chk("midrst_release_coef_ready", longint'(coef_ready), 1);
        fill_rand(blk_b);
        run_block(blk_b, 1'b0, 1'b1);
        check_model("after_rst", blk_b);

        fill_dc(blk_a, 512);
        send_block(blk_a, 1'b0);
        pix_ready = 1'b0;
        budget    = 0;
        while (!pix_valid && budget < 200) begin
            step;
            budget++;
        end
        chk("emit_stall_valid", longint'(pix_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pix_valid", longint'(pix_valid), 0);
        step;
        rst_n = 1'b1;
        step;
        chk("async_release_coef_ready", longint'(coef_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
